ifu_fetch: RTL

//  Instruction fetch stage. Sits upstream of the instruction cache and downstream of nothing:
//  - owns the PC and issues one-cycle fetch requests to the icache;
//  - captures the returned instruction;
//  - hands {pc, inst} to the decode stage over a valid/ready handshake.
//  One fetch is outstanding at a time. Branch, jump and trap redirects arrive from later stages.

---
 rtl/ifu_fetch.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch
//  Description : Instruction fetch stage. Owns the PC and issues one-cycle
//                fetch requests to the instruction cache. It captures the
//                returned instruction and presents {pc, inst} to decode over
//                a valid/ready handshake. Only one fetch is outstanding at a
//                time. Redirects from later stages replace the PC.
//  Ports       :
//    clock, reset     - clock; asynchronous active-high reset
//    redirect_valid   - a later stage requests a PC change this cycle
//    redirect_pc      - redirect target (bits [1:0] ignored)
//    ic_require       - one-cycle fetch request to the icache
//    ic_pc            - fetch address
//    ic_inst_valid    - icache response pulse
//    ic_inst          - returned instruction
//    out_valid        - {out_pc, out_inst} valid for decode
//    out_ready        - decode accepts this cycle
//    out_pc, out_inst - delivered PC / instruction
//    perf_fetch       - count of completed decode handshakes (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        ic_require,
   output logic [31:0] ic_pc,
   input  logic        ic_inst_valid,
   input  logic [31:0] ic_inst,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic [31:0] perf_fetch
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_t;

   localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
   localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & PC_ALIGN_MASK;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc;
   logic [31:0] pc_next;
   logic        kill;
   logic        kill_next;
   logic [31:0] out_pc_next;
   logic [31:0] out_inst_next;
   logic [31:0] perf_next;
   logic [31:0] target_pc;

   // The PC is always word aligned, so the low bits of the target are dropped.
   assign target_pc = redirect_pc & PC_ALIGN_MASK;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= BOOT;
         pc         <= RESET_PC_ALIGNED;
         kill       <= 1'b0;
         out_pc     <= RESET_PC_ALIGNED;
         out_inst   <= 32'd0;
         perf_fetch <= 32'd0;
      end else begin
         state      <= state_next;
         pc         <= pc_next;
         kill       <= kill_next;
         out_pc     <= out_pc_next;
         out_inst   <= out_inst_next;
         perf_fetch <= perf_next;
      end
   end

   always_comb begin
      state_next    = state;
      pc_next       = pc;
      kill_next     = kill;
      out_pc_next   = out_pc;
      out_inst_next = out_inst;
      perf_next     = perf_fetch;

      case (state)
         BOOT: begin
            state_next = REQ;
         end

         // The request has already been seen by the icache, so a redirect
         // here only marks its response as stale.
         REQ: begin
            state_next = WAIT;
            if (redirect_valid) begin
               pc_next   = target_pc;
               kill_next = 1'b1;
            end
         end

         // The outstanding response must be drained before refetching,
         // because the icache has no way to cancel it.
         WAIT: begin
            if (!ic_inst_valid) begin
               if (redirect_valid) begin
                  pc_next   = target_pc;
                  kill_next = 1'b1;
               end
            end else if (kill || redirect_valid) begin
               kill_next  = 1'b0;
               state_next = REQ;
               if (redirect_valid) begin
                  pc_next = target_pc;
               end
            end else begin
               out_inst_next = ic_inst;
               out_pc_next   = pc;
               pc_next       = pc + 32'd4;
               state_next    = HOLD;
            end
         end

         // A redirect takes priority over decode accepting: the held
         // instruction is on the wrong path and is never counted.
         HOLD: begin
            if (redirect_valid) begin
               pc_next    = target_pc;
               state_next = REQ;
            end else if (out_ready) begin
               perf_next  = perf_fetch + 32'd1;
               state_next = REQ;
            end
         end

         default: begin
            state_next = BOOT;
         end
      endcase
   end

   assign ic_require = (state == REQ);
   assign ic_pc      = pc;
   assign out_valid  = (state == HOLD) && !redirect_valid;

endmodule
`default_nettype wire
